// File: rtl/load_store_unit.sv
// RV32I load/store unit: sized/sign-extended loads, SB/SH via read-modify-write, SW direct.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module load_store_unit #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse with rdata/resp_err held until the next pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_store_q, is_store_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_legal;
    logic              req_misal;
    logic              req_ok;
    logic [ADDR_W-1:0] req_addr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W];

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (f3[1:0] == 2'b00) begin
            r[{off, 3'b000} +: 8] = d[7:0];
        end else if (f3[1:0] == 2'b01) begin
            r[{off[1], 4'b0000} +: 16] = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    always_comb begin
        req_legal = 1'b0;
        req_misal = 1'b0;
        req_addr  = addr[ADDR_W-1:0];
        case (funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !is_store;
            default:                req_legal = 1'b0;
        endcase
        // Misaligned low bits are dropped so a non-trapping build accesses the aligned container.
        if (funct3[1:0] == 2'b01) begin
            req_misal   = addr[0];
            req_addr[0] = 1'b0;
        end else if (funct3[1:0] == 2'b10) begin
            req_misal     = |addr[1:0];
            req_addr[1:0] = 2'b00;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        req_ok = req_legal && !req_misal;
`else
        req_ok = req_legal;
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    wdata_d    = wdata;
                    if (!req_ok) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (is_store && funct3[1:0] == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                word_d = mem_rdata;
                if (is_store_q) begin
                    state_d = WR;
                end else begin
                    rdata_d = extract(mem_rdata, addr_q[1:0], funct3_q);
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WR: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
            wdata_q    <= 32'd0;
            word_q     <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Memory strobes come from the state register alone, so they cannot glitch with inputs.
    always_comb begin
        mem_read  = (state_q == RD);
        mem_write = (state_q == WR);
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (state_q == RD || state_q == WR) begin
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        end
        if (state_q == WR) begin
            mem_wdata = merge(word_q, addr_q[1:0], funct3_q, wdata_q);
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign rdata      = rdata_q;
    assign dbg_state  = state_q;

endmodule
